nios2_cpu_switch_capture: RTL and testbench
===========================================

NIOS2_CPU_SWITCH_CAPTURE -- requirements
Module: nios2_cpu_switch_capture

Interface
REQ-001 Parameter WIDTH, default 11: number of input bits; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per bit; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronised change must persist; legal range 1..65535.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 Port address, input, 2: Avalon-MM slave register select.
REQ-007 Port chipselect, input, 1: Avalon-MM slave select.
REQ-008 Port write_n, input, 1: Avalon-MM write strobe, active-low.
REQ-009 Port writedata, input, 32: Avalon-MM write data.
REQ-010 Port in_port, input, WIDTH: asynchronous external inputs, e.g. board switches.
REQ-011 Port readdata, output, 32: registered Avalon-MM read data.
REQ-012 Port irq, output, 1: level interrupt request, active-high.

Function
REQ-013 Each in_port bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronised value s.
REQ-014 Per bit, a debounce counter SHALL clear whenever s equals the stable value d.
- It SHALL increment on each cycle where s differs from d.
- d SHALL take the value of s on the cycle the count of consecutive mismatches reaches DEBOUNCE_CYCLES; the counter clears at the same edge.
REQ-015 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-016 A stable in_port change first sampled at edge 1 SHALL update d at edge SYNC_STAGES+DEBOUNCE_CYCLES; any s pulse shorter than DEBOUNCE_CYCLES cycles SHALL leave d unchanged.
REQ-017 Register map; write = chipselect & ~write_n; unused bits read 0; writes to read-only fields are ignored.
- 0 DATA (RO): d.
- 1 IRQMASK (RW): WIDTH bits.
- 2 EDGECAP (R/W1C): per-bit sticky edge flags.
- 3 EDGEMODE (RW): 2 bits; 0 = rising, 1 = falling, 2 and 3 = either edge.
REQ-018 An EDGECAP bit SHALL set at the same edge at which d changes in the direction selected by EDGEMODE.
REQ-019 A write to EDGECAP SHALL clear each bit whose writedata bit is 1. If a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-020 An EDGEMODE change SHALL affect only transitions of d occurring after the write edge; existing EDGECAP bits are retained.
REQ-021 readdata SHALL update every clock edge with the addressed register, independent of chipselect (read latency 1, no wait states).
REQ-022 irq SHALL equal the OR-reduction of (EDGECAP & IRQMASK). It is combinational from registers, with no extra latency beyond the register update.

Reset
REQ-023 When reset_n = 0 at a clock edge, the following SHALL clear to 0 at that edge: synchroniser flops, debounce counters, d, IRQMASK, EDGECAP, EDGEMODE and readdata. irq SHALL then be 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count.
REQ-025 After reset, an in_port bit held at 1 SHALL produce a rising edge in d per REQ-016 and SHALL set the corresponding EDGECAP bit; with IRQMASK = 0, irq SHALL stay 0.
REQ-026 While reset_n = 0, writes SHALL be ignored.

Verification
All scenarios use WIDTH = 11, SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4.
REQ-027 Rising edge and interrupt.
- Stimulus: in_port 0x000 -> 0x005 sampled at edge 1; EDGEMODE = 0; IRQMASK = 0x7FF.
- Response: d = 0x005 at edge 6; EDGECAP = 0x005 and irq = 1 at edge 6; a DATA read returns 0x00000005.
REQ-028 Glitch rejection.
- Stimulus: bit 3 pulses high for 3 cycles, then returns low.
- Response: DATA stays 0x000; EDGECAP is unchanged; irq is unchanged.
REQ-029 Clear/set collision.
- Stimulus: EDGECAP = 0x001; write 0x001 to address 2 at the same edge a new rising edge on bit 0 reaches d.
- Response: EDGECAP stays 0x001.
- Then a later write of 0x001 to address 2 gives EDGECAP = 0x000 and irq = 0.
REQ-030 Falling and either-edge modes.
- Stimulus: EDGEMODE = 1; bit 10 goes 1 -> 0.
- Response: EDGECAP = 0x400.
- Then with EDGEMODE = 2 and bit 10 going 0 -> 1 (after a W1C clear), EDGECAP = 0x400 again.
REQ-031 Reset mid-debounce.
- Stimulus: reset_n low for 1 cycle, 2 cycles after in_port changes to 0x7FF.
- Response: all registers are 0 after that edge.
- d becomes 0x7FF 6 edges after the first post-reset edge; EDGECAP = 0x7FF; irq = 0.
REQ-032 Mask gating and readback.
- Stimulus: IRQMASK = 0x002 with EDGECAP = 0x001.
- Response: irq = 0; reads of addresses 1 and 3 return 0x00000002 and the written mode, with upper bits 0.

Source files
------------

// File: rtl/nios2_cpu_switch_capture.sv
// nios2_cpu_switch_capture
//   Synchronises and debounces a bank of asynchronous inputs (board switches),
//   records per-bit edge events and exposes them on an Avalon-MM slave with a
//   level interrupt.
//
// Parameters
//   WIDTH           number of input bits (1..32)
//   SYNC_STAGES     synchroniser flops per bit (2..4)
//   DEBOUNCE_CYCLES consecutive cycles a synchronised change must persist (1..65535)
//
// Ports
//   clk        single clock for all logic
//   reset_n    synchronous active-low reset
//   address    register select: 0 DATA (RO), 1 IRQMASK (RW), 2 EDGECAP (W1C),
//              3 EDGEMODE (RW, 0 rising / 1 falling / 2,3 either)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   in_port    asynchronous inputs
//   readdata   registered read data, one cycle latency, follows address every cycle
//   irq        OR-reduction of EDGECAP & IRQMASK
module nios2_cpu_switch_capture #(
  parameter int unsigned WIDTH           = 11,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value seen on the cycle before the final mismatch; the next
  // mismatch is the DEBOUNCE_CYCLES-th one and commits the new value.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CntW-1:0]  cnt_q  [WIDTH];
  logic [CntW-1:0]  cnt_d  [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [1:0]       edgemode_q, edgemode_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] rise, fall, edge_set;
  logic             wr_en;

  // Only the low WIDTH bits of writedata feed registers.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign wdata_w = writedata[WIDTH-1:0];
  assign wr_en   = chipselect & ~write_n;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Per-bit debounce: the counter only runs while the synchronised input
  // disagrees with the stable value, and clears on any agreement.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

  always_comb begin
    edge_set = '0;
    unique case (edgemode_q)
      2'd0:       edge_set = rise;
      2'd1:       edge_set = fall;
      2'd2, 2'd3: edge_set = rise | fall;
    endcase
  end

  always_comb begin
    irqmask_d  = irqmask_q;
    edgemode_d = edgemode_q;
    edgecap_d  = edgecap_q;
    if (wr_en && address == 2'd1) irqmask_d = wdata_w;
    if (wr_en && address == 2'd3) edgemode_d = writedata[1:0];
    if (wr_en && address == 2'd2) edgecap_d = edgecap_q & ~wdata_w;
    // Set is applied after the clear so a coincident event wins.
    edgecap_d = edgecap_d | edge_set;
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d = zext(stable_q);
      2'd1: readdata_d = zext(irqmask_q);
      2'd2: readdata_d = zext(edgecap_q);
      2'd3: readdata_d = {30'b0, edgemode_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
      stable_q   <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      edgemode_q <= '0;
      readdata_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
      stable_q   <= stable_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      edgemode_q <= edgemode_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios2_cpu_switch_capture.sv
// Bench for nios2_cpu_switch_capture (WIDTH 11, SYNC_STAGES 2, DEBOUNCE_CYCLES 4).
// Register reads are queued with the cycle they are due on and checked by a
// monitor on the falling edge; irq is checked directly.
module tb_nios2_cpu_switch_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [10:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  nios2_cpu_switch_capture #(
    .WIDTH          (11),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  typedef struct {
    string       tag;
    int unsigned due;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t     sb_q[$];
  rd_exp_t     sb_e;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // readdata for an entry is valid after the edge numbered by its due cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_e = sb_q.pop_front();
      check(sb_e.tag, readdata, sb_e.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    address = addr;
    sb_q.push_back('{tag: tag, due: cyc + 1, exp: exp});
    tick();
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    ticks(2);
    reset_n = 1'b1;

    // Reset state
    check("rst_irq", {31'b0, irq}, 32'h0);
    expect_rd("rst_data", 2'd0, 32'h0);
    expect_rd("rst_mask", 2'd1, 32'h0);
    expect_rd("rst_cap",  2'd2, 32'h0);
    expect_rd("rst_mode", 2'd3, 32'h0);

    // Three-cycle pulse on bit 3 must be rejected
    in_port = 11'h008;
    ticks(3);
    in_port = 11'h000;
    ticks(8);
    expect_rd("glitch_data", 2'd0, 32'h0);
    expect_rd("glitch_cap",  2'd2, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // Rising edge: d updates at edge 6, readdata one edge later
    wr(2'd3, 32'h0);
    wr(2'd1, 32'h7FF);
    in_port = 11'h005;
    for (int k = 1; k <= 7; k++) begin
      expect_rd($sformatf("rise_data_e%0d", k), 2'd0, (k == 7) ? 32'h5 : 32'h0);
      if (k == 5) check("rise_irq_e5", {31'b0, irq}, 32'h0);
      if (k == 6) check("rise_irq_e6", {31'b0, irq}, 32'h1);
    end
    expect_rd("rise_cap", 2'd2, 32'h5);
    wr(2'd2, 32'h7FF);
    check("w1c_irq", {31'b0, irq}, 32'h0);
    expect_rd("w1c_cap", 2'd2, 32'h0);

    // Clear/set collision on bit 0
    in_port = 11'h004;
    ticks(8);
    in_port = 11'h005;
    ticks(8);
    expect_rd("coll_pre_cap", 2'd2, 32'h1);
    in_port = 11'h004;
    ticks(8);
    expect_rd("coll_fall_kept", 2'd2, 32'h1);
    in_port = 11'h005;
    ticks(5);
    wr(2'd2, 32'h1);
    expect_rd("coll_cap", 2'd2, 32'h1);
    check("coll_irq", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    check("coll_clr_irq", {31'b0, irq}, 32'h0);
    expect_rd("coll_clr_cap", 2'd2, 32'h0);
    expect_rd("coll_data", 2'd0, 32'h5);

    // Falling mode ignores rising, then captures falling; either-edge modes
    wr(2'd3, 32'h1);
    in_port = 11'h405;
    ticks(8);
    expect_rd("fall_rise_ign", 2'd2, 32'h0);
    in_port = 11'h005;
    ticks(8);
    expect_rd("fall_cap", 2'd2, 32'h400);
    check("fall_irq", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h400);
    wr(2'd3, 32'h2);
    in_port = 11'h405;
    ticks(8);
    expect_rd("either2_cap", 2'd2, 32'h400);
    wr(2'd2, 32'h7FF);
    wr(2'd3, 32'h3);
    in_port = 11'h005;
    ticks(8);
    expect_rd("either3_cap", 2'd2, 32'h400);

    // Mask gating, readback, ignored write to DATA, mode change keeps EDGECAP
    wr(2'd2, 32'h7FF);
    in_port = 11'h004;
    ticks(8);
    wr(2'd1, 32'h2);
    check("mask_irq", {31'b0, irq}, 32'h0);
    expect_rd("mask_rd", 2'd1, 32'h2);
    wr(2'd3, 32'hFFFF_FFFE);
    expect_rd("mode_rd", 2'd3, 32'h2);
    expect_rd("mode_keep_cap", 2'd2, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    expect_rd("mask_full_rd", 2'd1, 32'h7FF);
    check("mask_full_irq", {31'b0, irq}, 32'h1);
    wr(2'd0, 32'h123);
    expect_rd("data_ro", 2'd0, 32'h4);

    // Reset two cycles into a change to 0x7FF, with a write that must be ignored
    in_port = 11'h7FF;
    ticks(2);
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd3;
    writedata  = 32'h3;
    sb_q.push_back('{tag: "mid_rst_rd", due: cyc + 1, exp: 32'h0});
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    reset_n    = 1'b1;
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      expect_rd($sformatf("post_rst_data_e%0d", k), 2'd0, (k == 7) ? 32'h7FF : 32'h0);
      check($sformatf("post_rst_irq_e%0d", k), {31'b0, irq}, 32'h0);
    end
    expect_rd("post_rst_cap",  2'd2, 32'h7FF);
    expect_rd("post_rst_mask", 2'd1, 32'h0);
    expect_rd("post_rst_mode", 2'd3, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    ticks(2);
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
